// File: rtl/ascon_p_round_if.sv
// Bus bundle for the Ascon-p round stage: input state with round index, and the
// registered result lanes with their valid flag.
interface ascon_p_round_if;
    logic        in_valid;
    logic [3:0]  round_cnt;
    logic [63:0] x0_i;
    logic [63:0] x1_i;
    logic [63:0] x2_i;
    logic [63:0] x3_i;
    logic [63:0] x4_i;
    logic [63:0] x0_o;
    logic [63:0] x1_o;
    logic [63:0] x2_o;
    logic [63:0] x3_o;
    logic [63:0] x4_o;
    logic        out_valid;

    modport master (
        output in_valid, round_cnt, x0_i, x1_i, x2_i, x3_i, x4_i,
        input  x0_o, x1_o, x2_o, x3_o, x4_o, out_valid
    );

    modport slave (
        input  in_valid, round_cnt, x0_i, x1_i, x2_i, x3_i, x4_i,
        output x0_o, x1_o, x2_o, x3_o, x4_o, out_valid
    );
endinterface

// File: rtl/ascon_p_round.sv
// Ascon-p round engine: UNROLL combinational permutation rounds feeding one
// result register; the caller owns the round counter and the state feedback.
module ascon_p_round #(
    parameter int UNROLL = 1
) (
    input logic            clk,
    input logic            rst,
    ascon_p_round_if.slave bus
);
    typedef logic [4:0][63:0] lanes_t;

    generate
        if (UNROLL < 1 || UNROLL > 3) begin : g_bad_unroll
            $error("ascon_p_round: UNROLL must be 1, 2 or 3");
        end
    endgenerate

    lanes_t nxt;
    lanes_t result;
    logic   valid_q;

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // Out-of-range indices simply wrap through the 4-bit arithmetic; the core
    // never drives them, so no clamping is spent on them.
    function automatic lanes_t round_fn(input lanes_t s, input logic [3:0] k);
        lanes_t      x;
        logic [3:0]  tt;
        logic [63:0] t0, t1, t2, t3, t4;
        x  = s;
        tt = 4'd12 - k;
        x[2] = x[2] ^ {56'd0, ~tt, tt};

        x[0] = x[0] ^ x[4];
        x[4] = x[4] ^ x[3];
        x[2] = x[2] ^ x[1];
        t0 = ~x[0] & x[1];
        t1 = ~x[1] & x[2];
        t2 = ~x[2] & x[3];
        t3 = ~x[3] & x[4];
        t4 = ~x[4] & x[0];
        x[0] = x[0] ^ t1;
        x[1] = x[1] ^ t2;
        x[2] = x[2] ^ t3;
        x[3] = x[3] ^ t4;
        x[4] = x[4] ^ t0;
        x[1] = x[1] ^ x[0];
        x[0] = x[0] ^ x[4];
        x[3] = x[3] ^ x[2];
        x[2] = ~x[2];

        x[0] = x[0] ^ ror(x[0], 19) ^ ror(x[0], 28);
        x[1] = x[1] ^ ror(x[1], 61) ^ ror(x[1], 39);
        x[2] = x[2] ^ ror(x[2], 1)  ^ ror(x[2], 6);
        x[3] = x[3] ^ ror(x[3], 10) ^ ror(x[3], 17);
        x[4] = x[4] ^ ror(x[4], 7)  ^ ror(x[4], 41);
        return x;
    endfunction

    always_comb begin
        nxt = {bus.x4_i, bus.x3_i, bus.x2_i, bus.x1_i, bus.x0_i};
        for (int j = 0; j < UNROLL; j++) begin
            nxt = round_fn(nxt, bus.round_cnt - 4'(j));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                result <= nxt;
            end
        end
    end

    assign bus.x0_o      = result[0];
    assign bus.x1_o      = result[1];
    assign bus.x2_o      = result[2];
    assign bus.x3_o      = result[3];
    assign bus.x4_o      = result[4];
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_ascon_p_round.sv
// Bench for ascon_p_round: drives UNROLL=1,2,3 instances side by side and checks
// them every cycle against a table-driven Ascon-p model.
module tb_ascon_p_round;
    typedef logic [4:0][63:0] state_t;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    logic   iv   [3];
    logic [3:0] rc [3];
    state_t xin  [3];
    state_t xout [3];
    logic   ov   [3];

    state_t exp_out [3];
    logic   exp_ov  [3];

    int checks = 0;
    int errors = 0;

    logic [4:0] sbox_tab [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };
    int rot_a [5] = '{19, 61, 1, 10, 7};
    int rot_b [5] = '{28, 39, 6, 17, 41};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ascon_p_round_if bus ();
        ascon_p_round #(.UNROLL(g + 1)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
        assign bus.in_valid  = iv[g];
        assign bus.round_cnt = rc[g];
        assign bus.x0_i      = xin[g][0];
        assign bus.x1_i      = xin[g][1];
        assign bus.x2_i      = xin[g][2];
        assign bus.x3_i      = xin[g][3];
        assign bus.x4_i      = xin[g][4];
        assign xout[g]       = {bus.x4_o, bus.x3_o, bus.x2_o, bus.x1_o, bus.x0_o};
        assign ov[g]         = bus.out_valid;
    end

    function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
        logic [127:0] d;
        d = {v, v} >> n;
        return d[63:0];
    endfunction

    function automatic logic [7:0] rc_const(input int k);
        int t;
        t = (12 - k) & 15;
        return 8'(((15 - t) << 4) | t);
    endfunction

    // The S-box is applied as a 32-entry lookup per bit column, x0 being the MSB.
    function automatic state_t model_round(input state_t s, input int k);
        state_t     r;
        state_t     a;
        logic [4:0] idx;
        logic [4:0] o;
        a = s;
        a[2] = a[2] ^ {56'd0, rc_const(k)};
        for (int b = 0; b < 64; b++) begin
            idx = {a[0][b], a[1][b], a[2][b], a[3][b], a[4][b]};
            o   = sbox_tab[idx];
            for (int i = 0; i < 5; i++) r[i][b] = o[4 - i];
        end
        for (int i = 0; i < 5; i++)
            r[i] = r[i] ^ ror64(r[i], rot_a[i]) ^ ror64(r[i], rot_b[i]);
        return r;
    endfunction

    function automatic state_t model_rounds(input state_t s, input int k, input int n);
        state_t x;
        x = s;
        for (int j = 0; j < n; j++) x = model_round(x, (k - j) & 15);
        return x;
    endfunction

    always @(posedge clk or negedge rst) begin
        for (int g = 0; g < 3; g++) begin
            if (!rst) begin
                exp_out[g] <= '0;
                exp_ov[g]  <= 1'b0;
            end else begin
                exp_ov[g] <= iv[g];
                if (iv[g]) exp_out[g] <= model_rounds(xin[g], int'(rc[g]), g + 1);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [319:0] act, input logic [319:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            checkOutput($sformatf("cycle_valid_u%0d", g + 1), 320'(ov[g]), 320'(exp_ov[g]));
            checkOutput($sformatf("cycle_lanes_u%0d", g + 1), xout[g], exp_out[g]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int g, input logic v, input int k, input state_t s);
        iv[g]  = v;
        rc[g]  = 4'(k);
        xin[g] = s;
    endtask

    function automatic state_t rand_state();
        state_t s;
        for (int i = 0; i < 5; i++) s[i] = {$urandom(), $urandom()};
        return s;
    endfunction

    // Loops every instance over a full permutation of nr rounds in parallel.
    task automatic run_perm(input int nr, input state_t s0);
        state_t ref_s;
        int     cnt [3];
        ref_s = model_rounds(s0, nr, nr);
        for (int g = 0; g < 3; g++) cnt[g] = 0;
        for (int cyc = 0; cyc <= nr; cyc++) begin
            for (int g = 0; g < 3; g++) begin
                if (cnt[g] < nr / (g + 1)) begin
                    applyStimulus(g, 1'b1, nr - cnt[g] * (g + 1), (cnt[g] == 0) ? s0 : xout[g]);
                    cnt[g]++;
                end else begin
                    applyStimulus(g, 1'b0, 0, rand_state());
                end
            end
            step();
        end
        for (int g = 0; g < 3; g++)
            checkOutput($sformatf("perm_p%0d_u%0d", nr, g + 1), xout[g], ref_s);
    endtask

    state_t zero_s;
    state_t lit12;
    state_t ref6;
    state_t s_rand;

    initial begin
        zero_s = '0;
        lit12  = {64'h0, 64'h3C780000000000F0, 64'h3FFFFFFFFFFFFF74,
                  64'h00000001E0000770, 64'h001E0F00000000F0};

        checkOutput("rc_k12", 320'(rc_const(12)), 320'h0F0);
        checkOutput("rc_k6",  320'(rc_const(6)),  320'h096);
        checkOutput("rc_k1",  320'(rc_const(1)),  320'h04B);
        checkOutput("model_zero_k12", model_rounds(zero_s, 12, 1), lit12);

        for (int g = 0; g < 3; g++) applyStimulus(g, 1'b1, 12, rand_state());
        repeat (3) step();
        for (int g = 0; g < 3; g++) begin
            checkOutput($sformatf("reset_lanes_u%0d", g + 1), xout[g], '0);
            checkOutput($sformatf("reset_valid_u%0d", g + 1), 320'(ov[g]), '0);
        end

        rst = 1'b1;
        for (int g = 0; g < 3; g++) applyStimulus(g, 1'b1, 12, zero_s);
        step();
        checkOutput("zero_k12_lanes", xout[0], lit12);
        checkOutput("zero_k12_valid", 320'(ov[0]), 320'd1);

        for (int g = 0; g < 3; g++) applyStimulus(g, 1'b1, 6, zero_s);
        step();
        checkOutput("zero_k6_lanes", xout[0], model_rounds(zero_s, 6, 1));
        for (int g = 0; g < 3; g++) applyStimulus(g, 1'b1, 1, zero_s);
        step();
        checkOutput("zero_k1_lanes", xout[0], model_rounds(zero_s, 1, 1));

        for (int rep = 0; rep < 2; rep++) begin
            run_perm(12, rand_state());
            s_rand = rand_state();
            run_perm(6, s_rand);
        end
        ref6 = model_rounds(s_rand, 6, 6);

        for (int c = 0; c < 3; c++) begin
            for (int g = 0; g < 3; g++) applyStimulus(g, 1'b0, c, rand_state());
            step();
        end
        for (int g = 0; g < 3; g++) begin
            checkOutput($sformatf("hold_lanes_u%0d", g + 1), xout[g], ref6);
            checkOutput($sformatf("hold_valid_u%0d", g + 1), 320'(ov[g]), '0);
        end

        s_rand = rand_state();
        for (int c = 0; c < 3; c++) begin
            for (int g = 0; g < 3; g++)
                applyStimulus(g, 1'b1, 12 - c * (g + 1), (c == 0) ? s_rand : xout[g]);
            step();
        end
        #2;
        rst = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            checkOutput($sformatf("async_rst_lanes_u%0d", g + 1), xout[g], '0);
            checkOutput($sformatf("async_rst_valid_u%0d", g + 1), 320'(ov[g]), '0);
        end
        step();
        rst = 1'b1;
        for (int g = 0; g < 3; g++) applyStimulus(g, 1'b0, 0, zero_s);
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ascon_p_round.md
Name: ascon_p_round

Overview:
- Registered Ascon-p round engine: applies UNROLL consecutive Ascon permutation rounds (constant addition, 5-bit S-box layer, linear diffusion layer) to a 320-bit state of five 64-bit lanes.
- The state register stays in the AEAD core; this block is the datapath stage that core clocks once per round step.
- Round index is driven by the core's down-counting round counter: 12..1 for p^a, 6..1 for p^b.

Parameters:
- UNROLL, 1, rounds computed per clock; legal values 1, 2, 3; other values rejected at elaboration.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- in_valid  in  1  a state is presented for processing this cycle
- round_cnt  in  4  round index of the first round applied this cycle
- x0_i..x4_i  in  64 each  input lanes x0..x4; bit 63 = MSB
- x0_o..x4_o  out  64 each  registered result lanes
- out_valid  out  1  x*_o holds a freshly computed result

Behaviour:
- Reset (rst=0, asynchronous, independent of clk):
  - x0_o..x4_o = 0, out_valid = 0.
  - Reset asserted mid-operation discards the in-flight result.
- On each rising clk with rst=1:
  - out_valid <= in_valid.
  - If in_valid=1: x*_o <= R(r-UNROLL+1) o ... o R(r-1) o R(r)(x*_i), where r = round_cnt.
  - If in_valid=0: x*_o holds its value.
- Latency: exactly 1 cycle for every UNROLL value.
- Round k, 4-bit arithmetic throughout:
  - Index for sub-round j (0-based within the cycle) = round_cnt - j, mod 16.
  - t = 12 - k mod 16; c = ((15 - t) << 4) | t, 8 bits zero-extended.
  - Examples: k=12 -> 0xF0; k=6 -> 0x96; k=1 -> 0x4B.
  - Out-of-range k (0, 13..15) uses the same formula; no error, no clamping.
- Constant addition: x2 ^= c.
- S-box, in order:
  - x0^=x4; x4^=x3; x2^=x1.
  - t_i = ~x_i & x_(i+1 mod 5), all five t computed from the same values.
  - x_i ^= t_(i+1 mod 5).
  - x1^=x0; x0^=x4; x3^=x2; x2=~x2.
- Linear layer (ror = rotate right on 64 bits):
  - x0 ^= ror(x0,19)^ror(x0,28)
  - x1 ^= ror(x1,61)^ror(x1,39)
  - x2 ^= ror(x2,1)^ror(x2,6)
  - x3 ^= ror(x3,10)^ror(x3,17)
  - x4 ^= ror(x4,7)^ror(x4,41)
- Datapath constraints:
  - Round logic is purely combinational between the inputs and the output register.
  - No internal round state; the caller advances round_cnt by UNROLL each step and feeds x*_o back.
- Back-to-back in_valid cycles are fully supported: one result per cycle.

Test Plan:
1. Reset: hold rst=0 with random inputs and in_valid=1 -> all x*_o = 0, out_valid = 0; release rst -> first result appears one edge later.
2. UNROLL=1, all-zero lanes, round_cnt=12, in_valid=1 -> next cycle:
   - x0_o=0x001E0F00000000F0
   - x1_o=0x00000001E0000770
   - x2_o=0x3FFFFFFFFFFFFF74
   - x3_o=0x3C780000000000F0
   - x4_o=0
   - out_valid=1
3. Constant check: same zero state with round_cnt=6 and round_cnt=1 -> results match a golden model using x2 constants 0x96 and 0x4B respectively.
4. Full permutations: loop x*_o back 12 cycles (round_cnt 12..1) and 6 cycles (6..1) on random states -> final lanes equal a software Ascon-p12 / p6 reference; repeat with UNROLL=2 (6 and 3 cycles) and UNROLL=3 (4 and 2 cycles) -> identical results.
5. Hold: after a result, drive in_valid=0 with changing x*_i -> x*_o unchanged, out_valid=0; assert rst mid-loop -> outputs 0 immediately, without waiting for a clock edge.
